// File: rtl/seg7_scan_ctrl_if.sv
// Write port of the 7-segment scan controller.
//   wr_en   : 1-cycle write strobe, always accepted
//   wr_data : packed BCD digits, [3:0]=digit0 (LSD) .. [15:12]=digit3 (MSD)
//   dp      : decimal point per digit, bit n = digit n, sampled with wr_en
//   wr_ack  : 1-cycle pulse when a pending write is committed to the display
// master = value producer (counter/timer logic), slave = scan controller.
interface seg7_scan_ctrl_if;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [3:0]  dp;
  logic        wr_ack;

  modport master (output wr_en, output wr_data, output dp, input wr_ack);
  modport slave  (input wr_en, input wr_data, input dp, output wr_ack);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan scheduler for a 4-digit common-anode 7-segment display.
// A written BCD value is held pending and committed only at frame start, so
// all four digits of one frame always come from the same write. Each digit
// slot starts with a blanking gap (all digits off) to avoid ghosting.
// Ports:
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   wr_if   : write port (slave side), see seg7_scan_ctrl_if
//   i_lz_en : leading-zero suppression enable (level, sampled live)
//   o_seg   : segments {a,b,c,d,e,f,g,dp}, active-high, registered
//   o_dig   : digit enables, active-low, bit n = digit n, registered
module seg7_scan_ctrl #(
  parameter int unsigned TICK_CYCLES  = 27_000,
  parameter int unsigned BLANK_CYCLES = 270
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  seg7_scan_ctrl_if.slave    wr_if,
  input  logic               i_lz_en,
  output logic [7:0]         o_seg,
  output logic [3:0]         o_dig
);

  localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST     = CW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] CYC_BLK_LAST = CW'(BLANK_CYCLES - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [CW-1:0] cyc_q, cyc_d;
  logic [1:0]    slot_q, slot_d;
  logic [0:0]    state_q, state_d;
  logic [15:0]   disp_q, disp_d;
  logic [3:0]    disp_dp_q, disp_dp_d;
  logic [15:0]   pend_q, pend_d;
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic          pend_vld_q, pend_vld_d;
  logic          ack_q, ack_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    dig_q, dig_d;

  logic          slot_end;
  logic          commit;
  logic [3:0]    digit;
  logic          suppress;

  function automatic logic [7:0] seg_decode(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'd0:    s = 8'hFC;
      4'd1:    s = 8'h60;
      4'd2:    s = 8'hDA;
      4'd3:    s = 8'hF2;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'hB6;
      4'd6:    s = 8'hBE;
      4'd7:    s = 8'hE0;
      4'd8:    s = 8'hFE;
      4'd9:    s = 8'hF6;
      default: s = 8'h02;  // non-BCD nibble shows '-'
    endcase
    return s;
  endfunction

  // Scan timing and frame-start commit.
  // state_q is SHOW exactly while cyc_q >= BLANK_CYCLES; it is loaded one
  // cycle early so it lines up with cyc_q.
  always_comb begin
    slot_end = (cyc_q == CYC_LAST);
    commit   = slot_end && (slot_q == 2'd3) && pend_vld_q;

    cyc_d  = slot_end ? '0 : cyc_q + 1'b1;
    slot_d = slot_end ? slot_q + 2'd1 : slot_q;

    state_d = state_q;
    if (slot_end)
      state_d = ST_BLANK;
    else if (cyc_q == CYC_BLK_LAST)
      state_d = ST_SHOW;

    // Commit takes the value pending before this edge; a write landing on
    // the same cycle stays pending for the next frame.
    disp_d    = commit ? pend_q    : disp_q;
    disp_dp_d = commit ? pend_dp_q : disp_dp_q;
    ack_d     = commit;

    pend_d     = wr_if.wr_en ? wr_if.wr_data : pend_q;
    pend_dp_d  = wr_if.wr_en ? wr_if.dp      : pend_dp_q;
    pend_vld_d = wr_if.wr_en ? 1'b1 : (commit ? 1'b0 : pend_vld_q);
  end

  // Output decode for the current slot, registered below.
  always_comb begin
    digit = disp_q[{slot_q, 2'b00} +: 4];

    // A digit is a leading zero when it and every higher digit are zero.
    case (slot_q)
      2'd3:    suppress = (disp_q[15:12] == 4'd0);
      2'd2:    suppress = (disp_q[15:8]  == 8'd0);
      2'd1:    suppress = (disp_q[15:4]  == 12'd0);
      default: suppress = 1'b0;
    endcase
    suppress = suppress && i_lz_en;

    seg_d = '0;
    dig_d = '1;
    if ((state_q == ST_SHOW) && !suppress) begin
      dig_d = ~(4'b0001 << slot_q);
      seg_d = seg_decode(digit) | {7'b0, disp_dp_q[slot_q]};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cyc_q      <= '0;
      slot_q     <= '0;
      state_q    <= ST_BLANK;
      disp_q     <= '0;
      disp_dp_q  <= '0;
      pend_q     <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      ack_q      <= 1'b0;
      seg_q      <= '0;
      dig_q      <= '1;
    end else begin
      cyc_q      <= cyc_d;
      slot_q     <= slot_d;
      state_q    <= state_d;
      disp_q     <= disp_d;
      disp_dp_q  <= disp_dp_d;
      pend_q     <= pend_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      ack_q      <= ack_d;
      seg_q      <= seg_d;
      dig_q      <= dig_d;
    end
  end

  assign o_seg        = seg_q;
  assign o_dig        = dig_q;
  assign wr_if.wr_ack = ack_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with TICK_CYCLES=20, BLANK_CYCLES=4.
// Observed word per check: {3'b000, o_wr_ack, o_dig[3:0], o_seg[7:0]}.
// Edge k counts rising edges since reset release; after edge k the outputs
// reflect the scan position of edge k-1 (cyc=(k-1)%20, slot=((k-1)/20)%4).
module tb_seg7_scan_ctrl;
  logic       clk;
  logic       rst_n;
  logic       lz_en;
  logic [7:0] seg;
  logic [3:0] dig;

  int unsigned vectors;
  int unsigned miscompares;
  int unsigned cyc_n;
  int unsigned ack_seen;

  seg7_scan_ctrl_if wr_if ();

  seg7_scan_ctrl #(.TICK_CYCLES(20), .BLANK_CYCLES(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .wr_if   (wr_if),
    .i_lz_en (lz_en),
    .o_seg   (seg),
    .o_dig   (dig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc_n = cyc_n + 1;
  endtask

  task automatic run_to(input int unsigned k);
    while (cyc_n < k) step();
  endtask

  task automatic do_write(input logic [15:0] data, input logic [3:0] dp);
    wr_if.wr_en   = 1'b1;
    wr_if.wr_data = data;
    wr_if.dp      = dp;
    step();
    wr_if.wr_en   = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [15:0] expected);
    logic [15:0] observed;
    observed = {3'b000, wr_if.wr_ack, dig, seg};
    vectors = vectors + 1;
    assert (observed === expected)
    else begin
      miscompares = miscompares + 1;
      $error("FAIL %s @edge %0d observed=%h expected=%h", tag, cyc_n, observed, expected);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    cyc_n = 0;
    ack_seen = 0;
    rst_n = 1'b0;
    lz_en = 1'b0;
    wr_if.wr_en = 1'b0;
    wr_if.wr_data = '0;
    wr_if.dp = '0;

    // 1: reset and first slot
    repeat (10) step();
    chk("in_reset", 16'h0F00);
    rst_n = 1'b1;
    cyc_n = 0;
    run_to(1);  chk("rel_blank", 16'h0F00);
    run_to(4);  chk("blank_end", 16'h0F00);
    run_to(5);  chk("first_show", 16'h0EFC);

    // 2: write 1234, committed at edge 80
    run_to(6);  do_write(16'h1234, 4'b0000);
    run_to(79); chk("no_tear_pre", 16'h07FC);
    run_to(80); chk("ack_1234", 16'h17FC);
    run_to(81); chk("ack_drop", 16'h0F00);
    run_to(85); chk("d0_4", 16'h0E66);
    run_to(105); chk("d1_3", 16'h0DF2);
    run_to(125); chk("d2_2", 16'h0BDA);
    run_to(145); chk("d3_1", 16'h0760);
    run_to(160); chk("no_2nd_ack", 16'h0760);

    // 3: write 0007 with leading-zero suppression, committed at edge 240
    run_to(161); lz_en = 1'b1; do_write(16'h0007, 4'b0000);
    run_to(240); chk("ack_0007", 16'h1760);
    run_to(245); chk("lz_d0", 16'h0EE0);
    run_to(265); chk("lz_d1", 16'h0F00);
    run_to(285); chk("lz_d2", 16'h0F00);
    run_to(305); chk("lz_d3", 16'h0F00);
    lz_en = 1'b0;
    run_to(306); chk("lz_off_d3", 16'h07FC);
    run_to(325); chk("nolz_d0", 16'h0EE0);
    run_to(345); chk("nolz_d1", 16'h0DFC);

    // 4: non-BCD nibble with decimal point, committed at edge 400
    run_to(349); do_write(16'h00A5, 4'b0010);
    run_to(400); chk("ack_00A5", 16'h17FC);
    run_to(405); chk("d0_5", 16'h0EB6);
    run_to(425); chk("d1_dash_dp", 16'h0D03);
    run_to(445); chk("d2_0", 16'h0BFC);

    // 5: overwrite before commit, and a write on the exact wrap edge (560)
    run_to(489); do_write(16'h1111, 4'b0000);
    run_to(499); do_write(16'h2222, 4'b0000);
    run_to(559); do_write(16'h3333, 4'b0000);
    chk("ack_2222", 16'h17FC);
    run_to(561); chk("single_ack", 16'h0F00);
    run_to(565); chk("f1_d0_2", 16'h0EDA);
    run_to(585); chk("f1_d1_2", 16'h0DDA);
    run_to(640); chk("ack_3333", 16'h17DA);
    run_to(645); chk("f2_d0_3", 16'h0EF2);
    run_to(705); chk("f2_d3_3", 16'h07F2);
    run_to(720); chk("no_3rd_ack", 16'h07F2);

    // 6: reset mid-SHOW of slot 2 with a write pending
    run_to(729); do_write(16'h9999, 4'b1111);
    run_to(770); chk("slot2_show", 16'h0BF2);
    rst_n = 1'b0;
    #1;
    chk("async_rst", 16'h0F00);
    repeat (3) step();
    rst_n = 1'b1;
    cyc_n = 0;
    run_to(1); chk("rst2_blank", 16'h0F00);
    run_to(5); chk("rst2_show0", 16'h0EFC);
    while (cyc_n < 170) begin
      step();
      if (wr_if.wr_ack === 1'b1) ack_seen = ack_seen + 1;
    end
    chk("rst2_d0_zero", 16'h0EFC);
    vectors = vectors + 1;
    assert (ack_seen == 0)
    else begin
      miscompares = miscompares + 1;
      $error("FAIL rst2_no_ack observed=%0d expected=0", ack_seen);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
